// File: rtl/tpu_feeder_pkg.sv
// Shared types and default sizes for the input skew feeder.
package tpu_feeder_pkg;

    localparam int unsigned FEEDER_LANES  = 16;
    localparam int unsigned FEEDER_DW     = 8;
    localparam int unsigned FEEDER_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

    typedef logic [FEEDER_DW-1:0] lane_vec_t [FEEDER_LANES-1:0];

endpackage

// File: rtl/skew_delay_line.sv
// Per-lane {valid,data} shift register; data is zeroed whenever valid is low.
module skew_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          valid_in,
    input  logic [DW-1:0] data_in,
    output logic          valid_out,
    output logic [DW-1:0] data_out
);

    logic [DEPTH-1:0]         vld_sr;
    logic [DEPTH-1:0][DW-1:0] dat_sr;

    // Shift one stage per cycle; flush empties the whole line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
            dat_sr <= '0;
        end else if (flush) begin
            vld_sr <= '0;
            dat_sr <= '0;
        end else begin
            vld_sr[0] <= valid_in;
            dat_sr[0] <= valid_in ? data_in : '0;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                dat_sr[i] <= dat_sr[i-1];
            end
        end
    end

    assign valid_out = vld_sr[DEPTH-1];
    assign data_out  = dat_sr[DEPTH-1];

endmodule

// File: rtl/input_skew_feeder.sv
// Streams a tile of UB input vectors and skews lane k by k cycles for the array.
module input_skew_feeder
    import tpu_feeder_pkg::*;
#(
    parameter int unsigned LANES  = FEEDER_LANES,
    parameter int unsigned DW     = FEEDER_DW,
    parameter int unsigned ADDR_W = FEEDER_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [ADDR_W-1:0]          num_rows,
    output logic                       ub_rd_input_en,
    output logic [ADDR_W-1:0]          ub_rd_input_addr_in,
    input  logic [LANES-1:0][DW-1:0]   ub_rd_input_data_out,
    output logic [LANES-1:0][DW-1:0]   sa_data_out,
    output logic [LANES-1:0]           sa_valid_out,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned DRAIN_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LANES - 1);

    feeder_state_t       state, state_nxt;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   num_q;
    logic [ADDR_W-1:0]   row_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                accept;
    logic                in_fetch;
    logic                flush;
    logic [ADDR_W-1:0]   last_row;

    assign accept   = (state == IDLE) && start && !abort;
    assign in_fetch = (state == FETCH);
    assign flush    = abort && (state != IDLE);
    assign last_row = num_q - ADDR_W'(1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort outside IDLE always returns to IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (num_rows == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (row_cnt == last_row) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Tile parameters are captured only when a start is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            num_q  <= '0;
        end else if (accept) begin
            base_q <= base_addr;
            num_q  <= num_rows;
        end
    end

    // Row and drain counters run only in their own state and restart from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            row_cnt   <= in_fetch ? row_cnt + ADDR_W'(1) : '0;
            drain_cnt <= (state == DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
        end
    end

    // UB read port and status outputs decode directly from state.
    always_comb begin
        ub_rd_input_en      = in_fetch;
        ub_rd_input_addr_in = in_fetch ? (base_q + row_cnt) : '0;
        busy                = (state == FETCH) || (state == DRAIN);
        done                = (state == DONE);
    end

    // Lane k sees k+1 register stages, giving the diagonal wavefront.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        skew_delay_line #(
            .DEPTH (k + 1),
            .DW    (DW)
        ) u_skew (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .valid_in  (in_fetch),
            .data_in   (ub_rd_input_data_out[k]),
            .valid_out (sa_valid_out[k]),
            .data_out  (sa_data_out[k])
        );
    end

endmodule

// File: tb/tb_input_skew_feeder.sv
// Self-checking bench for input_skew_feeder: scenario table plus random tiles.
module tb_input_skew_feeder;

    logic               clk;
    logic               rst;
    logic               start;
    logic               abort;
    logic [9:0]         base_addr;
    logic [9:0]         num_rows;
    logic               ub_en;
    logic [9:0]         ub_addr;
    logic [15:0][7:0]   ub_data;
    logic [15:0][7:0]   sa_data;
    logic [15:0]        sa_valid;
    logic               busy;
    logic               done;

    logic [15:0][7:0]   ub_mem [0:1023];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state for the tile currently being run.
    int m_base, m_n, m_abort, m_rst;
    bit basic_chk;

    input_skew_feeder #(
        .LANES  (16),
        .DW     (8),
        .ADDR_W (10)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .abort                (abort),
        .base_addr            (base_addr),
        .num_rows             (num_rows),
        .ub_rd_input_en       (ub_en),
        .ub_rd_input_addr_in  (ub_addr),
        .ub_rd_input_data_out (ub_data),
        .sa_data_out          (sa_data),
        .sa_valid_out         (sa_valid),
        .busy                 (busy),
        .done                 (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational UB read port.
    assign ub_data = ub_mem[ub_addr];

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=-1 got=timeout want=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int c, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, c, act, exp);
        end
    endtask

    // Expected outputs in tile cycle c, straight from the timing rules.
    function automatic void model(input int c, output logic e_en, output logic [9:0] e_addr,
                                  output logic e_busy, output logic e_done,
                                  output logic [15:0] e_vld, output logic [15:0][7:0] e_dat);
        e_en = 1'b0; e_addr = '0; e_busy = 1'b0; e_done = 1'b0; e_vld = '0; e_dat = '0;
        if (c < 1) return;
        if (m_abort >= 0 && c > m_abort) return;
        if (m_rst >= 0 && c >= m_rst) return;
        if (c <= m_n) begin
            e_en   = 1'b1;
            e_addr = 10'((m_base + c - 1) % 1024);
        end
        e_busy = (m_n > 0) && (c <= m_n + 16);
        e_done = (m_n == 0) ? (c == 1) : (c == m_n + 17);
        for (int k = 0; k < 16; k++) begin
            int r;
            r = c - 1 - k;
            if (r >= 1 && r <= m_n) begin
                e_vld[k] = 1'b1;
                e_dat[k] = ub_mem[(m_base + r - 1) % 1024][k];
            end
        end
    endfunction

    task automatic check_cycle(input int c);
        logic e_en, e_busy, e_done;
        logic [9:0] e_addr;
        logic [15:0] e_vld;
        logic [15:0][7:0] e_dat;
        model(c, e_en, e_addr, e_busy, e_done, e_vld, e_dat);
        chk("en",    c, 128'(ub_en),    128'(e_en));
        chk("addr",  c, 128'(ub_addr),  128'(e_addr));
        chk("busy",  c, 128'(busy),     128'(e_busy));
        chk("done",  c, 128'(done),     128'(e_done));
        chk("valid", c, 128'(sa_valid), 128'(e_vld));
        chk("data",  c, 128'(sa_data),  128'(e_dat));
    endtask

    task automatic chk_all_zero(input string name, input int c);
        chk({name, "_en"},    c, 128'(ub_en),    '0);
        chk({name, "_addr"},  c, 128'(ub_addr),  '0);
        chk({name, "_busy"},  c, 128'(busy),     '0);
        chk({name, "_done"},  c, 128'(done),     '0);
        chk({name, "_valid"}, c, 128'(sa_valid), '0);
        chk({name, "_data"},  c, 128'(sa_data),  '0);
    endtask

    // Runs one tile starting at posedge+1 of its cycle 0; returns observed done/busy stats.
    task automatic run_tile(input int base, input int n, input int abort_c, input int start2_c,
                            input int rst_c, output int done_c, output int busy_n, output int done_n);
        int end_c;
        m_base = base; m_n = n; m_abort = abort_c; m_rst = rst_c;
        if (rst_c >= 0)        end_c = rst_c + 1;
        else if (abort_c == 0) end_c = 4;
        else if (abort_c > 0)  end_c = abort_c + 1;
        else if (n == 0)       end_c = 1;
        else                   end_c = n + 17;
        done_c = -1; busy_n = 0; done_n = 0;
        for (int c = 0; c <= end_c; c++) begin
            start = (c == 0) || (c == start2_c);
            if (c == 0) begin
                base_addr = 10'(base);
                num_rows  = 10'(n);
            end else if (c == start2_c) begin
                base_addr = 10'(base + 300);
                num_rows  = 10'(n + 2);
            end else begin
                base_addr = 10'($urandom);
                num_rows  = 10'($urandom);
            end
            abort = (c == abort_c);
            if (rst_c >= 0 && c == rst_c + 1) rst = 1'b0;
            if (c == rst_c) begin
                #2 rst = 1'b1;
                #1 chk_all_zero("async_rst", c);
            end
            @(negedge clk);
            check_cycle(c);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            if (basic_chk) begin
                if (c == 7)  chk("basic_l5_c7",  c, 128'(sa_data[5]), 128'(8'h05));
                if (c == 8)  chk("basic_l5_c8",  c, 128'(sa_data[5]), 128'(8'h15));
                if (c == 9)  chk("basic_l5_c9",  c, 128'(sa_data[5]), 128'(8'h25));
                if (c == 19) chk("basic_l15_v19", c, 128'(sa_valid[15]), 128'(1'b1));
                if (c == 20) chk("basic_l15_v20", c, 128'(sa_valid[15]), 128'(1'b0));
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    typedef struct {
        int base;
        int n;
        int abort_c;
        int start2_c;
        int rst_c;
        int exp_done_c;
        int exp_busy;
        int exp_done_n;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int dc, bn, dn;
        tbl[0] = '{16,   3,    -1, -1, -1, 20,   19,   1};
        tbl[1] = '{1022, 4,    -1, -1, -1, 21,   20,   1};
        tbl[2] = '{42,   0,    -1, -1, -1, 1,    0,    1};
        tbl[3] = '{64,   10,    4, -1, -1, -1,   4,    0};
        tbl[4] = '{100,  5,    -1, -1, -1, 22,   21,   1};
        tbl[5] = '{200,  6,    -1,  2, -1, 23,   22,   1};
        tbl[6] = '{300,  5,     0, -1, -1, -1,   0,    0};
        tbl[7] = '{40,   3,    -1, -1,  8, -1,   7,    0};
        tbl[8] = '{7,    1,    -1, -1, -1, 18,   17,   1};
        tbl[9] = '{5,    1023, -1, -1, -1, 1040, 1039, 1};

        rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; num_rows = '0;
        basic_chk = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            ub_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                ub_mem[16 + r][i] = 8'(16 * r + i);
            end
        end

        #3 chk_all_zero("reset", 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int t = 0; t < 10; t++) begin
            basic_chk = (t == 0);
            run_tile(tbl[t].base, tbl[t].n, tbl[t].abort_c, tbl[t].start2_c, tbl[t].rst_c, dc, bn, dn);
            chk($sformatf("tbl%0d_done_cycle", t), t, 128'(dc), 128'(tbl[t].exp_done_c));
            chk($sformatf("tbl%0d_busy_cycles", t), t, 128'(bn), 128'(tbl[t].exp_busy));
            chk($sformatf("tbl%0d_done_pulses", t), t, 128'(dn), 128'(tbl[t].exp_done_n));
        end
        basic_chk = 1'b0;

        for (int t = 0; t < 30; t++) begin
            int b, n, a;
            b = int'($urandom_range(0, 1023));
            n = int'($urandom_range(0, 40));
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n + 18)) : -1;
            run_tile(b, n, a, -1, -1, dc, bn, dn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
